usb_tx_packet_builder: RTL and testbench

USB_TX_PACKET_BUILDER -- requirements
Module: usb_tx_packet_builder

---
 rtl/usb_tx_pkg.sv | 44 ++++
 rtl/usb_tx_packet_builder_if.sv | 9 +
 rtl/usb_tx_crc16.sv | 21 ++
 rtl/usb_tx_packet_builder.sv | 128 ++++++++++++
 tb/tb_usb_tx_packet_builder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet builder: FSM states,
// PID codes, SYNC byte and the CRC16 polynomial with its byte-update function.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_REQ,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [7:0]  SYNC_BYTE  = 8'h01;
    localparam logic [15:0] CRC16_POLY = 16'h8005;  // x^16 + x^15 + x^2 + 1
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    // Bits go out LSB first, so the register runs reflected and the
    // polynomial is applied bit-reversed.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] poly_rev;
        logic [15:0] c;
        for (int i = 0; i < 16; i++) poly_rev[i] = CRC16_POLY[15-i];
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ poly_rev;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_tx_packet_builder_if.sv
// TX FIFO read port: occupancy and data from the FIFO, pop strobe back to it.
interface usb_tx_packet_builder_if;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_data;
    logic       get_data;

    modport master (input buffer_occupancy, input tx_data, output get_data);
    modport slave  (output buffer_occupancy, output tx_data, input get_data);
endinterface

// File: rtl/usb_tx_crc16.sv
// USB CRC16 accumulator: cleared to the init value, updated one byte per enable.
module usb_tx_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     crc <= CRC16_INIT;
        else if (clear) crc <= CRC16_INIT;
        else if (en)    crc <= crc16_byte(crc, data);
    end

endmodule

// File: rtl/usb_tx_packet_builder.sv
// Builds one USB packet (SYNC, PID, optional payload + CRC16) into a flat byte
// vector, popping payload bytes from the TX FIFO two cycles per byte.
module usb_tx_packet_builder
    import usb_tx_pkg::*;
#(
    parameter int MAX_DATA = 64,
    parameter int PKT_W    = 8 * (MAX_DATA + 4)
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [3:0]                      pid,
    usb_tx_packet_builder_if.master         fifo,
    output logic [PKT_W-1:0]                packet,
    output logic [$clog2(MAX_DATA+5)-1:0]   packet_bytes,
    output logic                            load_complete,
    output logic                            busy
);

    localparam int NUM_BYTES = PKT_W / 8;
    localparam int PB_W      = $clog2(MAX_DATA + 5);
    localparam int CNT_W     = $clog2(MAX_DATA + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             clear;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic             crc_en;
    logic [15:0]      crc;

    usb_tx_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .en    (crc_en),
        .data  (fifo.tx_data),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        clear         = 1'b0;
        wr_en         = 1'b0;
        wr_byte       = '0;
        crc_en        = 1'b0;
        fifo.get_data = 1'b0;
        load_complete = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                clear     = 1'b1;
                state_nxt = S_SYNC;
            end
            S_SYNC: begin
                wr_en     = 1'b1;
                wr_byte   = SYNC_BYTE;
                state_nxt = S_PID;
            end
            S_PID: begin
                wr_en     = 1'b1;
                wr_byte   = {~pid, pid};
                state_nxt = is_data_pid(pid) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (fifo.buffer_occupancy != '0 && count < CNT_MAX) begin
                    fifo.get_data = 1'b1;
                    state_nxt     = S_DATA;
                end else begin
                    state_nxt = S_CRC_LO;
                end
            end
            S_DATA: begin
                wr_en     = 1'b1;
                wr_byte   = fifo.tx_data;
                crc_en    = 1'b1;
                state_nxt = S_REQ;
            end
            S_CRC_LO: begin
                wr_en     = 1'b1;
                wr_byte   = ~crc[7:0];
                state_nxt = S_CRC_HI;
            end
            S_CRC_HI: begin
                wr_en     = 1'b1;
                wr_byte   = ~crc[15:8];
                state_nxt = S_DONE;
            end
            S_DONE: begin
                load_complete = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every written byte lands at index packet_bytes, so a single write port
    // serves SYNC, PID, payload and CRC bytes alike.
    // NOTE: the packet byte array is reset explicitly because unused bytes
    // must read zero straight out of reset, unlike a plain storage RAM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            packet       <= '0;
            packet_bytes <= '0;
            count        <= '0;
        end else if (clear) begin
            packet       <= '0;
            packet_bytes <= '0;
            count        <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (packet_bytes == PB_W'(i)) packet[8*i +: 8] <= wr_byte;
            end
            packet_bytes <= packet_bytes + PB_W'(1);
            if (state == S_DATA) count <= count + CNT_W'(1);
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Self-checking bench for usb_tx_packet_builder (MAX_DATA=8): directed table,
// reset/abort and start-while-busy sequences, then randomized packets.
module tb_usb_tx_packet_builder;

    localparam int MAX_DATA  = 8;
    localparam int PKT_W     = 8 * (MAX_DATA + 4);
    localparam int NUM_BYTES = PKT_W / 8;
    localparam int PB_W      = $clog2(MAX_DATA + 5);

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       pid = 4'h0;
    logic [PKT_W-1:0] packet;
    logic [PB_W-1:0]  packet_bytes;
    logic             load_complete;
    logic             busy;

    usb_tx_packet_builder_if fifo();

    usb_tx_packet_builder #(.MAX_DATA(MAX_DATA)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .pid           (pid),
        .fifo          (fifo),
        .packet        (packet),
        .packet_bytes  (packet_bytes),
        .load_complete (load_complete),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gd_pulses = 0;
    int lc_pulses = 0;
    int bad_gd = 0;
    logic [7:0] q[$];

    // FIFO model: pop on get_data (data valid the following cycle), and
    // refresh occupancy only on cycles without a pop.
    always @(negedge clk) begin
        if (fifo.get_data) begin
            if (q.size() > 0) fifo.tx_data = q.pop_front();
            else              fifo.tx_data = 8'h00;
        end else begin
            fifo.buffer_occupancy = (q.size() > 127) ? 7'd127 : 7'(q.size());
        end
    end

    always @(negedge clk) begin
        if (fifo.get_data) gd_pulses++;
        if (fifo.get_data && fifo.buffer_occupancy == 7'd0) bad_gd++;
        if (load_complete) lc_pulses++;
    end

    task automatic check(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference CRC: plain MSB-first shift register on 0x8005 fed with each
    // byte's bits LSB first; the transmitted value is its bit-reversed inverse.
    function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
        logic [15:0] r;
        logic [15:0] t;
        logic        fb;
        r = 16'hFFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ d[k][b];
                r  = r << 1;
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) t[i] = r[15-i];
        return ~t;
    endfunction

    task automatic model_packet(input logic [3:0] p, input logic [7:0] data[$],
                                output logic [PKT_W-1:0] exp_pkt, output int exp_len,
                                output int exp_pulses, output int exp_lat);
        logic [7:0]  b[$];
        logic [7:0]  pl[$];
        logic [15:0] c;
        int          n;
        b.push_back(8'h01);
        b.push_back({~p, p});
        n = 0;
        if (p == 4'b0011 || p == 4'b1011) begin
            n = (data.size() < MAX_DATA) ? data.size() : MAX_DATA;
            for (int j = 0; j < n; j++) pl.push_back(data[j]);
            c = model_crc(pl);
            foreach (pl[j]) b.push_back(pl[j]);
            b.push_back(c[7:0]);
            b.push_back(c[15:8]);
            exp_lat = 6 + 2 * n;
        end else begin
            exp_lat = 3;
        end
        exp_pkt = '0;
        foreach (b[i]) exp_pkt[8*i +: 8] = b[i];
        exp_len    = b.size();
        exp_pulses = n;
    endtask

    task automatic run_packet(input string tag, input logic [3:0] p, input logic [7:0] data[$],
                              input bit poke, input int exp_len, input int exp_pulses,
                              input bit has_lo, input logic [31:0] lo);
        logic [PKT_W-1:0] exp_pkt;
        int m_len, m_pulses, exp_lat, cycles, g0, l0;
        model_packet(p, data, exp_pkt, m_len, m_pulses, exp_lat);
        q = data;
        step();
        g0 = gd_pulses;
        l0 = lc_pulses;
        pid = p;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 1;
        while (!load_complete && cycles < 300) begin
            start = poke && (cycles % 3 == 0);
            step();
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_bytes"}, packet_bytes, exp_len);
        check({tag, "_pulses"}, gd_pulses - g0, exp_pulses);
        check({tag, "_packet"}, packet, exp_pkt);
        if (has_lo) check({tag, "_lo_word"}, packet[31:0], lo);
        step();
        check({tag, "_lc_once"}, {load_complete, busy}, 2'b00);
        repeat (4) step();
        check({tag, "_held"}, packet, exp_pkt);
        check({tag, "_single"}, {lc_pulses - l0, busy}, {32'd1, 1'b0});
    endtask

    typedef struct {
        logic [3:0]  pid;
        int          fill;
        logic [23:0] head;
        int          exp_len;
        int          exp_pulses;
        bit          has_lo;
        logic [31:0] lo;
    } vec_t;

    initial begin
        vec_t       vecs[10];
        logic [7:0] d[$];
        logic [3:0] rp;
        int         m_len, m_pulses, m_lat;
        logic [PKT_W-1:0] m_pkt;

        vecs[0] = '{4'b0010, 0,  24'h000000, 2,  0, 1'b1, 32'h0000D201};
        vecs[1] = '{4'b0011, 0,  24'h000000, 4,  0, 1'b1, 32'h0000C301};
        vecs[2] = '{4'b1011, 3,  24'h0F55AA, 7,  3, 1'b1, 32'h55AA4B01};
        vecs[3] = '{4'b0011, 20, 24'h332211, 12, 8, 1'b0, 32'h0};
        vecs[4] = '{4'b1010, 5,  24'h332211, 2,  0, 1'b1, 32'h00005A01};
        vecs[5] = '{4'b1110, 0,  24'h000000, 2,  0, 1'b1, 32'h00001E01};
        vecs[6] = '{4'b1011, 8,  24'h030201, 12, 8, 1'b0, 32'h0};
        vecs[7] = '{4'b0011, 1,  24'h0000E7, 5,  1, 1'b0, 32'h0};
        vecs[8] = '{4'b1101, 4,  24'h332211, 2,  0, 1'b1, 32'h00002D01};
        vecs[9] = '{4'b1011, 7,  24'hC0B0A0, 11, 7, 1'b0, 32'h0};

        repeat (3) step();
        check("reset_outputs", {packet, packet_bytes, fifo.get_data, load_complete, busy}, '0);
        n_rst = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 10; i++) begin
            d.delete();
            for (int j = 0; j < vecs[i].fill; j++)
                d.push_back((j < 3) ? vecs[i].head[8*j +: 8] : 8'(j * 29 + 7));
            run_packet($sformatf("vec%0d", i), vecs[i].pid, d, 1'b0,
                       vecs[i].exp_len, vecs[i].exp_pulses, vecs[i].has_lo, vecs[i].lo);
        end

        // Start pulses while busy must not launch a second packet.
        d = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_packet("poke", 4'b0011, d, 1'b1, 8, 4, 1'b0, 32'h0);

        // Reset in the middle of the payload aborts without load_complete.
        begin
            int l0, n;
            q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
            step();
            l0 = lc_pulses;
            pid = 4'b1011;
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (!fifo.get_data && n < 50) begin
                step();
                n++;
            end
            step();
            check("abort_in_data_busy", busy, 1'b1);
            #2 n_rst = 1'b0;
            #1;
            check("abort_packet", packet, '0);
            check("abort_packet_bytes", packet_bytes, '0);
            check("abort_ctrl", {fifo.get_data, load_complete, busy}, 3'b000);
            step();
            n_rst = 1'b1;
            q.delete();
            repeat (20) step();
            check("abort_no_lc", {lc_pulses - l0, busy}, {32'd0, 1'b0});
        end

        d = '{8'hAA, 8'h55, 8'h0F};
        run_packet("after_reset", 4'b1011, d, 1'b0, 7, 3, 1'b1, 32'h55AA4B01);

        for (int i = 0; i < 25; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rp = (r < 4) ? 4'b0011 : (r < 8) ? 4'b1011 : 4'($urandom_range(0, 15));
            d.delete();
            for (int j = 0, f = $urandom_range(0, 12); j < f; j++) d.push_back(8'($urandom));
            model_packet(rp, d, m_pkt, m_len, m_pulses, m_lat);
            run_packet($sformatf("rnd%0d", i), rp, d, 1'($urandom_range(0, 1)),
                       m_len, m_pulses, 1'b0, 32'h0);
            repeat ($urandom_range(0, 3)) step();
        end

        check("get_data_with_zero_occupancy", bad_gd, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
